// File: rtl/uart_pkg.sv
// Shared UART frame constants and receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop conditioning of the async rx line with falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_d;

    // All stages reset high so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle po_flag per received byte.
// Optional stop-bit checking with frame_err when UART_RX_FRAME_CHECK_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] po_data,
    output logic                   po_flag
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_HALF    = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned BIT_CNT_W    = $clog2(UART_DATA_W);

    logic                   rx_s;
    logic                   fall;
    uart_rx_state_e         state;
    uart_rx_state_e         state_nxt;
    logic [CNT_W-1:0]       baud_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   baud_mid_c;
    logic                   baud_last_c;
    logic                   stop_hit_c;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    assign baud_mid_c  = (baud_cnt == CNT_W'(BAUD_HALF));
    assign baud_last_c = (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1));
    assign stop_hit_c  = (state == STOP) && baud_mid_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: every decision is taken at the middle of a bit period
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START:   if (baud_mid_c) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (baud_mid_c && (bit_cnt == BIT_CNT_W'(UART_DATA_W - 1))) state_nxt = STOP;
            STOP:    if (baud_mid_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-period counter free-runs through the frame and parks at zero in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if ((state == IDLE) || (state_nxt == IDLE) || baud_last_c) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // LSB-first data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == START) begin
            bit_cnt <= '0;
        end else if ((state == DATA) && baud_mid_c) begin
            shift_reg[bit_cnt] <= rx_s;
            bit_cnt            <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    // Commit slot is the cycle right after the stop-bit sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po_data <= '0;
            po_flag <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else begin
            po_flag <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            frame_err <= 1'b0;
            if (stop_hit_c) begin
                if (rx_s) begin
                    po_data <= shift_reg;
                    po_flag <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
`else
            if (stop_hit_c) begin
                po_data <= shift_reg;
                po_flag <= 1'b1;
            end
`endif
        end
    end

endmodule
